// File: rtl/iddr_train.sv
// Multi-lane DDR input capture with per-lane tap-delay training (sweep, widest window, centre).
// Optional eye-width statistics are built when IDDR_TRAIN_STATS_EN is defined.
module iddr_train #(
    parameter int   LANES         = 4,
    parameter int   TAP_W         = 5,
    parameter int   TAP_MAX       = 31,
    parameter int   DEFAULT_TAP   = 16,
    parameter int   SETTLE_CYCLES = 8,
    parameter int   CHECK_CYCLES  = 16,
    parameter logic TRAIN_Q1      = 1'b1,
    parameter logic TRAIN_Q2      = 1'b0,
    localparam int  LANE_W        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANES-1:0]             d_dly,
    output logic [LANES-1:0]             q1,
    output logic [LANES-1:0]             q2,
    output logic [LANES*TAP_W-1:0]       tap_out,
    output logic [LANES-1:0]             tap_load,
    input  logic                         train_start,
    output logic                         busy,
    output logic                         done,
    output logic [LANES-1:0]             lane_fail,
    input  logic                         man_wr,
    input  logic [LANE_W-1:0]            man_lane,
    input  logic [TAP_W-1:0]             man_tap,
    output logic [LANES*(TAP_W+1)-1:0]   eye_width
);

    localparam int LEN_W   = TAP_W + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        NEXT   = 3'd4,
        CENTER = 3'd5,
        FIN    = 3'd6
    } state_t;

    function automatic logic lane_valid(input logic [LANE_W-1:0] l);
        return (32'(l) < 32'(LANES));
    endfunction

    logic [LANES-1:0] r1_r, r2_r, q1_r, q2_r;

    state_t            state_r, state_s;
    logic [LANE_W-1:0] lane_r, lane_s;
    logic [TAP_W-1:0]  tap_r, tap_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              fail_r, fail_s;
    logic [LEN_W-1:0]  run_len_r, run_len_s;
    logic [TAP_W-1:0]  run_start_r, run_start_s;
    logic [LEN_W-1:0]  best_len_r, best_len_s;
    logic [TAP_W-1:0]  best_start_r, best_start_s;
    logic [TAP_W-1:0]  tap_out_r [LANES];
    logic [TAP_W-1:0]  tap_out_s [LANES];
    logic [LANES-1:0]  tap_load_r, tap_load_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [LANES-1:0]  lane_fail_r, lane_fail_s;
    logic              init_r;
    logic [TAP_W-1:0]  center_s;
`ifdef IDDR_TRAIN_STATS_EN
    logic [LEN_W-1:0]  eye_r [LANES];
    logic [LEN_W-1:0]  eye_s [LANES];
`endif

    // Rising-edge sample and re-registration of both phases onto the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_r <= {LANES{1'b0}};
            q1_r <= {LANES{1'b0}};
            q2_r <= {LANES{1'b0}};
        end else begin
            r1_r <= d_dly;
            q1_r <= r1_r;
            q2_r <= r2_r;
        end
    end

    // Falling-edge sample.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_r <= {LANES{1'b0}};
        end else begin
            r2_r <= d_dly;
        end
    end

    // Centre of the widest window; (len-1)/2 rounds toward the lower tap.
    assign center_s = best_start_r + TAP_W'((best_len_r - LEN_W'(1)) >> 1);

    // Next-state and datapath update for the training controller.
    always_comb begin
        state_s      = state_r;
        lane_s       = lane_r;
        tap_s        = tap_r;
        cnt_s        = cnt_r;
        fail_s       = fail_r;
        run_len_s    = run_len_r;
        run_start_s  = run_start_r;
        best_len_s   = best_len_r;
        best_start_s = best_start_r;
        tap_out_s    = tap_out_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        lane_fail_s  = lane_fail_r;
`ifdef IDDR_TRAIN_STATS_EN
        eye_s        = eye_r;
`endif
        if (init_r) begin
            tap_load_s = {LANES{1'b1}};
        end else begin
            tap_load_s = {LANES{1'b0}};
        end

        case (state_r)
            IDLE: begin
                if (train_start) begin
                    state_s      = LOAD;
                    lane_s       = {LANE_W{1'b0}};
                    tap_s        = {TAP_W{1'b0}};
                    run_len_s    = {LEN_W{1'b0}};
                    run_start_s  = {TAP_W{1'b0}};
                    best_len_s   = {LEN_W{1'b0}};
                    best_start_s = {TAP_W{1'b0}};
                    busy_s       = 1'b1;
                    lane_fail_s  = {LANES{1'b0}};
                end else if (man_wr && lane_valid(man_lane)) begin
                    tap_out_s[man_lane]  = man_tap;
                    tap_load_s[man_lane] = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            LOAD: begin
                tap_out_s[lane_r]  = tap_r;
                tap_load_s[lane_r] = 1'b1;
                cnt_s              = {CNT_W{1'b0}};
                fail_s             = 1'b0;
                state_s            = SETTLE;
            end
            SETTLE: begin
                if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = CHECK;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            CHECK: begin
                // A single mismatch fails the tap, but the full window is still observed.
                fail_s = fail_r | (q1_r[lane_r] != TRAIN_Q1) | (q2_r[lane_r] != TRAIN_Q2);
                if (cnt_r == CNT_W'(CHECK_CYCLES - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = NEXT;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            NEXT: begin
                if (!fail_r) begin
                    run_len_s = run_len_r + LEN_W'(1);
                    if (run_len_r == {LEN_W{1'b0}}) begin
                        run_start_s = tap_r;
                    end else begin
                        run_start_s = run_start_r;
                    end
                end else begin
                    run_len_s = {LEN_W{1'b0}};
                end
                // Strictly greater, so an equal later window never displaces the lower one.
                if (run_len_s > best_len_r) begin
                    best_len_s   = run_len_s;
                    best_start_s = run_start_s;
                end else begin
                    best_len_s   = best_len_r;
                    best_start_s = best_start_r;
                end
                if (tap_r == TAP_W'(TAP_MAX)) begin
                    state_s = CENTER;
                end else begin
                    tap_s   = tap_r + TAP_W'(1);
                    state_s = LOAD;
                end
            end
            CENTER: begin
                if (best_len_r != {LEN_W{1'b0}}) begin
                    tap_out_s[lane_r] = center_s;
                end else begin
                    tap_out_s[lane_r]   = TAP_W'(DEFAULT_TAP);
                    lane_fail_s[lane_r] = 1'b1;
                end
                tap_load_s[lane_r] = 1'b1;
`ifdef IDDR_TRAIN_STATS_EN
                eye_s[lane_r] = best_len_r;
`endif
                if (lane_r == LANE_W'(LANES - 1)) begin
                    state_s = FIN;
                end else begin
                    lane_s       = lane_r + LANE_W'(1);
                    tap_s        = {TAP_W{1'b0}};
                    run_len_s    = {LEN_W{1'b0}};
                    run_start_s  = {TAP_W{1'b0}};
                    best_len_s   = {LEN_W{1'b0}};
                    best_start_s = {TAP_W{1'b0}};
                    state_s      = LOAD;
                end
            end
            FIN: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            lane_r       <= {LANE_W{1'b0}};
            tap_r        <= {TAP_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            fail_r       <= 1'b0;
            run_len_r    <= {LEN_W{1'b0}};
            run_start_r  <= {TAP_W{1'b0}};
            best_len_r   <= {LEN_W{1'b0}};
            best_start_r <= {TAP_W{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                tap_out_r[i] <= TAP_W'(DEFAULT_TAP);
            end
            tap_load_r   <= {LANES{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            lane_fail_r  <= {LANES{1'b0}};
            init_r       <= 1'b1;
        end else begin
            state_r      <= state_s;
            lane_r       <= lane_s;
            tap_r        <= tap_s;
            cnt_r        <= cnt_s;
            fail_r       <= fail_s;
            run_len_r    <= run_len_s;
            run_start_r  <= run_start_s;
            best_len_r   <= best_len_s;
            best_start_r <= best_start_s;
            tap_out_r    <= tap_out_s;
            tap_load_r   <= tap_load_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            lane_fail_r  <= lane_fail_s;
            init_r       <= 1'b0;
        end
    end

`ifdef IDDR_TRAIN_STATS_EN
    // Per-lane widest-window length from the most recent training.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                eye_r[i] <= {LEN_W{1'b0}};
            end
        end else begin
            eye_r <= eye_s;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_eye
        assign eye_width[g*LEN_W +: LEN_W] = eye_r[g];
    end
`else
    assign eye_width = {(LANES*LEN_W){1'b0}};
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_tap
        assign tap_out[g*TAP_W +: TAP_W] = tap_out_r[g];
    end

    assign q1        = q1_r;
    assign q2        = q2_r;
    assign tap_load  = tap_load_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign lane_fail = lane_fail_r;

endmodule
